cordic_vectoring_iter: RTL

- Iterative (one micro-rotation per clock) CORDIC engine in vectoring mode.
- Converts a signed Cartesian pair (x, y) into magnitude and phase, i.e. atan2 plus uncompensated magnitude.
- It is the inverse-direction companion of the rotation-mode pipeline: it recovers the angle that the pipeline consumes.
- Area-optimised; sits behind a valid/ready handshake on both sides.

---
 rtl/cordic_pkg.sv | 40 ++++
 rtl/cordic_vec_stage.sv | 40 ++++
 rtl/cordic_vectoring_iter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: arctangent table, FSM state type and reference constants.
// The table is kept at 32-bit turn resolution and rounded down to the angle width used.
package cordic_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} cordic_state_t;

  // Uncompensated gain of the micro-rotation chain; kept for reference only.
  localparam real CORDIC_GAIN = 1.646760258;

  localparam int ATAN_TBL_N = 31;

  // atan(2^-i) with one full turn = 2^32, rounded to nearest.
  localparam logic [31:0] ATAN_TURN32 [ATAN_TBL_N] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001
  };

  // +90 degrees in binary angle units of width aw.
  function automatic logic [31:0] quarter_turn(input int aw);
    return 32'd1 << (aw - 2);
  endfunction

  // atan(2^-i) in binary angle units of width aw, rounded to nearest.
  function automatic logic [31:0] atan_lsb(input int i, input int aw);
    int          sh;
    logic [32:0] v;
    sh = 32 - aw;
    v  = {1'b0, ATAN_TURN32[i[4:0]]};
    if (sh > 0)
      v = v + (33'd1 << (sh - 1));
    return 32'(v >> sh);
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring-mode CORDIC micro-rotation, purely combinational.
// Drives y toward zero; the accumulated angle tracks the rotation applied.
module cordic_vec_stage #(
  parameter int XW      = 18,
  parameter int ANGLE_W = 16,
  parameter int SHW     = 4
) (
  input  logic signed [XW-1:0]      x,
  input  logic signed [XW-1:0]      y,
  input  logic signed [ANGLE_W-1:0] z,
  input  logic        [SHW-1:0]     shift,
  input  logic signed [ANGLE_W-1:0] atan,
  output logic signed [XW-1:0]      x_next,
  output logic signed [XW-1:0]      y_next,
  output logic signed [ANGLE_W-1:0] z_next
);

  logic signed [XW-1:0] x_shr;
  logic signed [XW-1:0] y_shr;

  assign x_shr = x >>> shift;
  assign y_shr = y >>> shift;

  // y == 0 takes the positive branch.
  always_comb begin
    x_next = x;
    y_next = y;
    z_next = z;
    if (y[XW-1]) begin
      x_next = x - y_shr;
      y_next = y + x_shr;
      z_next = z - atan;
    end else begin
      x_next = x + y_shr;
      y_next = y - x_shr;
      z_next = z + atan;
    end
  end

endmodule

// File: rtl/cordic_vectoring_iter.sv
// Iterative vectoring CORDIC: (x, y) -> (K*|v|, atan2(y, x)), one micro-rotation per clock.
// Accepts a pair only from IDLE; the result is held in DONE until the consumer takes it.
module cordic_vectoring_iter
  import cordic_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ITER    = 14,
  parameter int ANGLE_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH-1:0]   x_in,
  input  logic signed [WIDTH-1:0]   y_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic        [WIDTH:0]     mag_out,
  output logic signed [ANGLE_W-1:0] phase_out
);

  // Two guard bits cover the sqrt(2)*K growth of the worst-case corner.
  localparam int XW = WIDTH + 2;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic signed [ANGLE_W-1:0] QUARTER = ANGLE_W'(quarter_turn(ANGLE_W));

  cordic_state_t              state_reg;
  logic signed [XW-1:0]       x_reg;
  logic signed [XW-1:0]       y_reg;
  logic signed [ANGLE_W-1:0]  z_reg;
  logic        [CW-1:0]       cnt_reg;
  logic                       zero_reg;
  logic        [WIDTH:0]      mag_reg;
  logic signed [ANGLE_W-1:0]  phase_reg;

  logic signed [XW-1:0]       x_ext;
  logic signed [XW-1:0]       y_ext;
  logic signed [XW-1:0]       x_fold;
  logic signed [XW-1:0]       y_fold;
  logic signed [ANGLE_W-1:0]  z_fold;
  logic signed [XW-1:0]       x_next;
  logic signed [XW-1:0]       y_next;
  logic signed [ANGLE_W-1:0]  z_next;

  logic signed [ANGLE_W-1:0]  atan_lut [ITER];

  generate
    for (genvar gi = 0; gi < ITER; gi++) begin : g_atan
      assign atan_lut[gi] = ANGLE_W'(atan_lsb(gi, ANGLE_W));
    end
  endgenerate

  assign x_ext = {{2{x_in[WIDTH-1]}}, x_in};
  assign y_ext = {{2{y_in[WIDTH-1]}}, y_in};

  // Rotate the left half-plane by +/-90 degrees so the iterations start with x >= 0.
  always_comb begin
    x_fold = x_ext;
    y_fold = y_ext;
    z_fold = '0;
    if (x_ext[XW-1]) begin
      if (!y_ext[XW-1]) begin
        x_fold = y_ext;
        y_fold = -x_ext;
        z_fold = QUARTER;
      end else begin
        x_fold = -y_ext;
        y_fold = x_ext;
        z_fold = -QUARTER;
      end
    end
  end

  cordic_vec_stage #(
    .XW      (XW),
    .ANGLE_W (ANGLE_W),
    .SHW     (CW)
  ) u_stage (
    .x      (x_reg),
    .y      (y_reg),
    .z      (z_reg),
    .shift  (cnt_reg),
    .atan   (atan_lut[cnt_reg]),
    .x_next (x_next),
    .y_next (y_next),
    .z_next (z_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      cnt_reg   <= '0;
      zero_reg  <= 1'b0;
      mag_reg   <= '0;
      phase_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            x_reg     <= x_fold;
            y_reg     <= y_fold;
            z_reg     <= z_fold;
            zero_reg  <= (x_in == '0) && (y_in == '0);
            cnt_reg   <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          x_reg <= x_next;
          y_reg <= y_next;
          z_reg <= z_next;
          if (cnt_reg == CW'(ITER - 1)) begin
            // atan2(0, 0) is undefined; report a clean zero instead of residue.
            mag_reg   <= zero_reg ? '0 : x_next[WIDTH:0];
            phase_reg <= zero_reg ? '0 : z_next;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign mag_out   = mag_reg;
  assign phase_out = phase_reg;

endmodule
